uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8x-oversampled UART receiver feeding an AXI-Stream RX FIFO.
//
// Ports:
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   i_rxd                   raw serial input, idle high
//   i_prescale              clock cycles per 1/8 bit, captured at each start edge
//   m_axis_tdata/tuser      head entry: received data (LSB first on wire) and its parity error
//   m_axis_tvalid/tready    FIFO not empty / consumer pops the head entry
//   o_fill                  FIFO occupancy, 0..FIFO_DEPTH
//   o_rx_busy               receiver is mid-frame
//   o_frame_error           one-cycle pulse when the stop bit is sampled low
//   o_overrun               one-cycle pulse when a good frame is dropped on a full FIFO
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rxd,
  input  logic [PRESCALE_W-1:0]         i_prescale,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_rx_busy,
  output logic                          o_frame_error,
  output logic                          o_overrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PRESCALE_W + 3;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned EW = DATA_BITS + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic                  fall;
  logic [PRESCALE_W-1:0] presc_q;
  logic [CW-1:0]         cnt_q, half, full, limit;
  logic                  tick;
  logic [BW-1:0]         bit_q;
  logic                  last_bit;
  logic [DATA_BITS-1:0]  data_q;
  logic                  perr_q, push_q, fe_q, ov_q;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wptr_q, rptr_q, fill;
  logic [EW-1:0]         head;
  logic                  full_fifo, pop, wr_en;

  // Synchronizer plus one history flop for edge detection. The history flop only
  // sees a 1->0 step after the line was high, so a line stuck low cannot retrigger.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign fall = rxd_prev_q & ~rxd_sync_q;

  // Sample strobe: half a bit into START (mid start bit), a full bit elsewhere.
  always_comb begin
    half     = {1'b0, presc_q, 2'b00};
    full     = {presc_q, 3'b000};
    limit    = (state_q == StStart) ? half : full;
    tick     = (state_q != StIdle) && (cnt_q == limit - CW'(1));
    last_bit = (bit_q == BW'(DATA_BITS - 1));
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fall) state_d = StStart;
      StStart:  if (tick) state_d = rxd_sync_q ? StIdle : StData;
      StData:   if (tick && last_bit) state_d = (PARITY != 0) ? StParity : StStop;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_rx_busy = (state_q != StIdle);
  end

  // Receive datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      fe_q   <= 1'b0;
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (fall) presc_q <= (i_prescale == '0) ? PRESCALE_W'(1) : i_prescale;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
      end
      if (tick) begin
        case (state_q)
          StStart: begin
            bit_q  <= '0;
            perr_q <= 1'b0;
          end
          StData: begin
            data_q <= {rxd_sync_q, data_q[DATA_BITS-1:1]};
            bit_q  <= bit_q + BW'(1);
          end
          StParity: perr_q <= (PARITY == 1) ? ~(^data_q ^ rxd_sync_q) : (^data_q ^ rxd_sync_q);
          StStop: begin
            push_q <= rxd_sync_q;
            fe_q   <= ~rxd_sync_q;
          end
          default: ;
        endcase
      end
    end
  end

  // RX FIFO; pointers carry one extra bit so full and empty are distinguishable.
  always_comb begin
    fill      = wptr_q - rptr_q;
    full_fifo = (fill == (AW + 1)'(FIFO_DEPTH));
    pop       = m_axis_tvalid && m_axis_tready;
    wr_en     = push_q && (!full_fifo || pop);
    head      = mem[rptr_q[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= {perr_q, data_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop)   rptr_q <= rptr_q + (AW + 1)'(1);
      ov_q <= push_q && full_fifo && !pop;
    end
  end

  // Data outputs are gated so they read zero whenever the FIFO is empty.
  always_comb begin
    m_axis_tvalid = (fill != '0);
    m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
    m_axis_tuser  = m_axis_tvalid ? head[DATA_BITS] : 1'b0;
    o_fill        = fill;
    o_frame_error = fe_q;
    o_overrun     = ov_q;
  end

endmodule
